rv32_div_unit: RTL

- Multi-cycle RV32M divide/remainder unit that sits beside the single-cycle ALU in the EX stage. It executes DIV, DIVU, REM and REMU.
- Uses a radix-2 restoring shift-subtract datapath: one quotient bit per clock.
- Operands arrive and results leave through valid/ready handshakes, so the pipeline stalls EX while the unit is busy.

---
 rtl/rv32_div_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/rv32_div_unit.sv
// rtl/rv32_div_unit.sv - RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, one quotient bit per clock
module rv32_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic             rem_sel_q;
  logic             neg_q;
  logic             neg_r;
  logic [XLEN-1:0]  dvd;
  logic [XLEN-1:0]  dvs;
  logic [XLEN-1:0]  rem;
  logic [CNT_W-1:0] counter;

  logic            signed_op, a_neg, b_neg, div_zero, ovf, q_bit;
  logic [XLEN-1:0] abs_a, abs_b, rem_nx, quo_nx, quo_fix, rem_fix;
  logic [XLEN:0]   rem_sh, diff;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & A[XLEN-1];
    b_neg     = signed_op & B[XLEN-1];
    abs_a     = a_neg ? -A : A;
    abs_b     = b_neg ? -B : B;
    div_zero  = (B == '0);
    ovf       = signed_op && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
    // Shift keeps the old remainder MSB so large unsigned divisors stay exact;
    // the borrow out of the XLEN+1 bit subtract is the inverted quotient bit.
    rem_sh    = {rem, dvd[XLEN-1]};
    diff      = rem_sh - {1'b0, dvs};
    q_bit     = ~diff[XLEN];
    rem_nx    = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx    = {dvd[XLEN-2:0], q_bit};
    quo_fix   = neg_q ? -quo_nx : quo_nx;
    rem_fix   = neg_r ? -rem_nx : rem_nx;
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem_sel_q <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      counter   <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem_sel_q <= op[1];
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            dvd       <= abs_a;
            dvs       <= abs_b;
            rem       <= '0;
            counter   <= CNT_W'(XLEN);
            if (div_zero) begin
              result    <= op[1] ? A : '1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (ovf) begin
              result    <= op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          dvd     <= quo_nx;
          rem     <= rem_nx;
          counter <= counter - 1'b1;
          if (counter == CNT_W'(1)) begin
            result    <= rem_sel_q ? rem_fix : quo_fix;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
